// File: rtl/clk_div_pkg.sv
// Shared constants and divisor helpers for the programmable clock divider bank.
package clk_div_pkg;

   localparam int unsigned DEF_CNT_W = 16;
   localparam int unsigned MIN_DIV   = 2;

   function automatic int unsigned clamp_div(input int unsigned v);
      return (v < MIN_DIV) ? MIN_DIV : v;
   endfunction

   function automatic int unsigned ceil_half(input int unsigned n);
      return (n + 1) >> 1;
   endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/pending divisor, registered clk_out and tick.
module clk_div_chan
   import clk_div_pkg::*;
#(
   parameter int unsigned CNT_W   = DEF_CNT_W,
   parameter int unsigned DEF_DIV = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             sync,
   input  logic             div_wr,
   input  logic [CNT_W-1:0] div_in,
   output logic             clk_out,
   output logic             tick,
   output logic             div_pend
);

   localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEF_DIV);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cur_div_q, cur_div_d;
   logic [CNT_W-1:0] pend_div_q, pend_div_d;
   logic [CNT_W-1:0] wr_val, lo_thr;
   logic             clk_out_q, clk_out_d;
   logic             tick_q, tick_d;
   logic             div_pend_q, div_pend_d;
   logic             wrap, apply;

   always_comb begin
      wr_val     = CNT_W'(clamp_div(32'(div_in)));
      lo_thr     = CNT_W'(ceil_half(32'(cur_div_q)));
      wrap       = (cnt_q == cur_div_q - ONE);
      apply      = sync | ~en | wrap;
      cnt_d      = '0;
      clk_out_d  = 1'b0;
      tick_d     = 1'b0;
      cur_div_d  = cur_div_q;
      pend_div_d = pend_div_q;
      div_pend_d = div_pend_q;

      if (!sync && en) begin
         cnt_d     = wrap ? '0 : cnt_q + ONE;
         clk_out_d = (cnt_d >= lo_thr);
         tick_d    = wrap;
      end

      // A write landing on an apply point goes straight to the active divisor.
      if (apply) begin
         cur_div_d  = div_wr ? wr_val : pend_div_q;
         pend_div_d = cur_div_d;
         div_pend_d = 1'b0;
      end else if (div_wr) begin
         pend_div_d = wr_val;
         div_pend_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         cur_div_q  <= RST_DIV;
         pend_div_q <= RST_DIV;
         clk_out_q  <= 1'b0;
         tick_q     <= 1'b0;
         div_pend_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         cur_div_q  <= cur_div_d;
         pend_div_q <= pend_div_d;
         clk_out_q  <= clk_out_d;
         tick_q     <= tick_d;
         div_pend_q <= div_pend_d;
      end
   end

   assign clk_out  = clk_out_q;
   assign tick     = tick_q;
   assign div_pend = div_pend_q;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of independent programmable clock dividers sharing a common phase-sync pulse.
module clk_div_bank
   import clk_div_pkg::*;
#(
   parameter int unsigned NUM_CH  = 4,
   parameter int unsigned CNT_W   = DEF_CNT_W,
   parameter int unsigned DEF_DIV = 10
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_CH-1:0]       en,
   input  logic                    sync,
   input  logic [NUM_CH-1:0]       div_wr,
   input  logic [NUM_CH*CNT_W-1:0] div_in,
   output logic [NUM_CH-1:0]       clk_out,
   output logic [NUM_CH-1:0]       tick,
   output logic [NUM_CH-1:0]       div_pend
);

   for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
      clk_div_chan #(
         .CNT_W   (CNT_W),
         .DEF_DIV (DEF_DIV)
      ) u_chan (
         .clk      (clk),
         .rst_n    (rst_n),
         .en       (en[g]),
         .sync     (sync),
         .div_wr   (div_wr[g]),
         .div_in   (div_in[g*CNT_W +: CNT_W]),
         .clk_out  (clk_out[g]),
         .tick     (tick[g]),
         .div_pend (div_pend[g])
      );
   end

endmodule

// File: tb/tb_clk_div_bank.sv
// Randomized and directed checks of clk_div_bank against a period-based reference model.
module tb_clk_div_bank;

   localparam int NUM_CH  = 4;
   localparam int CNT_W   = 16;
   localparam int DEF_DIV = 10;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic [NUM_CH-1:0]       en;
   logic                    sync;
   logic [NUM_CH-1:0]       div_wr;
   logic [NUM_CH*CNT_W-1:0] div_in;
   logic [NUM_CH-1:0]       clk_out, tick, div_pend;

   clk_div_bank #(
      .NUM_CH  (NUM_CH),
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .sync     (sync),
      .div_wr   (div_wr),
      .div_in   (div_in),
      .clk_out  (clk_out),
      .tick     (tick),
      .div_pend (div_pend)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   // Model: position within the current period, active/pending period lengths.
   int unsigned m_pos  [NUM_CH];
   int unsigned m_per  [NUM_CH];
   int unsigned m_next [NUM_CH];
   bit          m_pnd  [NUM_CH];
   bit          m_clk  [NUM_CH];
   bit          m_tick [NUM_CH];
   logic [NUM_CH-1:0] exp_clk, exp_tick, exp_pend;

   task automatic build_exp();
      for (int i = 0; i < NUM_CH; i++) begin
         exp_clk[i]  = m_clk[i];
         exp_tick[i] = m_tick[i];
         exp_pend[i] = m_pnd[i];
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NUM_CH; i++) begin
         m_pos[i] = 0; m_per[i] = DEF_DIV; m_next[i] = DEF_DIV;
         m_pnd[i] = 0; m_clk[i] = 0; m_tick[i] = 0;
      end
      build_exp();
   endtask

   task automatic model_edge();
      for (int i = 0; i < NUM_CH; i++) begin
         bit          boundary;
         int unsigned w;
         w = 32'(div_in[i*CNT_W +: CNT_W]);
         if (w < 2) w = 2;
         boundary = 0;
         if (sync || !en[i]) begin
            m_pos[i] = 0; m_clk[i] = 0; m_tick[i] = 0; boundary = 1;
         end else begin
            m_pos[i] = m_pos[i] + 1;
            m_tick[i] = (m_pos[i] == m_per[i]);
            if (m_tick[i]) begin
               m_pos[i] = 0; boundary = 1;
            end
            m_clk[i] = (m_pos[i] >= (m_per[i] + 1) / 2);
         end
         if (boundary) begin
            m_per[i]  = div_wr[i] ? w : m_next[i];
            m_next[i] = m_per[i];
            m_pnd[i]  = 0;
         end else if (div_wr[i]) begin
            m_next[i] = w;
            m_pnd[i]  = 1;
         end
      end
      build_exp();
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      cyc++;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = '0; sync = 1'b0; div_wr = '0; div_in = '0;
      #12;
      vectors++;
      if ({clk_out, tick, div_pend} !== '0) begin
         miscompares++;
         $display("FAIL reset_state got clk=%b tick=%b pend=%b exp all zero", clk_out, tick, div_pend);
      end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      en    = '1;
   endtask

   task automatic test_default_div();
      for (int k = 1; k <= 30; k++) begin
         step();
         vectors++;
         if ({clk_out, tick, div_pend} !== {exp_clk, exp_tick, exp_pend}) begin
            miscompares++;
            $display("FAIL default_model cyc=%0d got %b/%b/%b exp %b/%b/%b", cyc, clk_out, tick, div_pend, exp_clk, exp_tick, exp_pend);
         end
         vectors++;
         if (tick[0] !== (k % 10 == 0) || clk_out[0] !== ((k % 10) >= 5)) begin
            miscompares++;
            $display("FAIL default_wave edge=%0d got clk=%b tick=%b exp clk=%b tick=%b", k, clk_out[0], tick[0], (k % 10) >= 5, k % 10 == 0);
         end
      end
   endtask

   task automatic test_write_three();
      int last;
      for (int k = 0; k < 4; k++) step();
      div_wr = 4'b0010; div_in[1*CNT_W +: CNT_W] = 16'd3;
      step();
      div_wr = '0;
      vectors++;
      if (div_pend[1] !== 1'b1) begin
         miscompares++;
         $display("FAIL write3_pend got %b exp 1", div_pend[1]);
      end
      last = -1;
      for (int k = 0; k < 25; k++) begin
         step();
         vectors++;
         if ({clk_out, tick, div_pend} !== {exp_clk, exp_tick, exp_pend}) begin
            miscompares++;
            $display("FAIL write3_model cyc=%0d got %b/%b/%b exp %b/%b/%b", cyc, clk_out, tick, div_pend, exp_clk, exp_tick, exp_pend);
         end
         if (tick[1]) begin
            if (last >= 0) begin
               vectors++;
               if (cyc - last != 3) begin
                  miscompares++;
                  $display("FAIL write3_period got %0d exp 3", cyc - last);
               end
            end
            last = cyc;
         end
      end
   endtask

   task automatic test_clamp();
      logic [1:0] prev;
      div_wr = 4'b1100;
      div_in[2*CNT_W +: CNT_W] = 16'd0;
      div_in[3*CNT_W +: CNT_W] = 16'd1;
      step();
      div_wr = '0;
      prev = clk_out[3:2];
      for (int k = 0; k < 24; k++) begin
         step();
         vectors++;
         if ({clk_out, tick, div_pend} !== {exp_clk, exp_tick, exp_pend}) begin
            miscompares++;
            $display("FAIL clamp_model cyc=%0d got %b/%b/%b exp %b/%b/%b", cyc, clk_out, tick, div_pend, exp_clk, exp_tick, exp_pend);
         end
         if (k >= 14) begin
            vectors++;
            if (clk_out[3:2] !== ~prev || tick[3:2] !== ~clk_out[3:2]) begin
               miscompares++;
               $display("FAIL clamp_div2 cyc=%0d got clk=%b tick=%b exp clk=%b tick=%b", cyc, clk_out[3:2], tick[3:2], ~prev, ~clk_out[3:2]);
            end
         end
         prev = clk_out[3:2];
      end
   endtask

   task automatic test_last_write();
      int last;
      div_wr = 4'b0001; div_in[0 +: CNT_W] = 16'd7;
      step();
      div_in[0 +: CNT_W] = 16'd5;
      step();
      div_wr = '0;
      vectors++;
      if (div_pend[0] !== 1'b1) begin
         miscompares++;
         $display("FAIL lastwr_pend got %b exp 1", div_pend[0]);
      end
      last = -1;
      for (int k = 0; k < 20; k++) begin
         step();
         vectors++;
         if ({clk_out, tick, div_pend} !== {exp_clk, exp_tick, exp_pend}) begin
            miscompares++;
            $display("FAIL lastwr_model cyc=%0d got %b/%b/%b exp %b/%b/%b", cyc, clk_out, tick, div_pend, exp_clk, exp_tick, exp_pend);
         end
         if (tick[0]) begin
            if (last >= 0) begin
               vectors++;
               if (cyc - last != 5) begin
                  miscompares++;
                  $display("FAIL lastwr_period got %0d exp 5", cyc - last);
               end
            end
            last = cyc;
         end
      end
   endtask

   task automatic test_sync();
      int first;
      en = 4'b1000; div_wr = 4'b0111;
      div_in[0*CNT_W +: CNT_W] = 16'd4;
      div_in[1*CNT_W +: CNT_W] = 16'd6;
      div_in[2*CNT_W +: CNT_W] = 16'd9;
      step();
      div_wr = '0; en = '1;
      vectors++;
      if (div_pend[2:0] !== 3'b000) begin
         miscompares++;
         $display("FAIL sync_apply_pend got %b exp 000", div_pend[2:0]);
      end
      for (int k = 0; k < 7; k++) step();
      sync = 1'b1;
      step();
      sync = 1'b0;
      vectors++;
      if (clk_out !== '0 || tick !== '0) begin
         miscompares++;
         $display("FAIL sync_zero got clk=%b tick=%b exp 0000/0000", clk_out, tick);
      end
      first = -1;
      for (int k = 1; k <= 40; k++) begin
         step();
         vectors++;
         if ({clk_out, tick, div_pend} !== {exp_clk, exp_tick, exp_pend}) begin
            miscompares++;
            $display("FAIL sync_model cyc=%0d got %b/%b/%b exp %b/%b/%b", cyc, clk_out, tick, div_pend, exp_clk, exp_tick, exp_pend);
         end
         if (first < 0 && tick[2:0] === 3'b111) first = k;
      end
      vectors++;
      if (first != 36) begin
         miscompares++;
         $display("FAIL sync_lcm got %0d exp 36", first);
      end
   endtask

   task automatic test_disable_and_reset();
      int first;
      for (int k = 0; k < 2; k++) step();
      en[2] = 1'b0;
      step();
      vectors++;
      if (clk_out[2] !== 1'b0 || tick[2] !== 1'b0) begin
         miscompares++;
         $display("FAIL disable_zero got clk=%b tick=%b exp 0/0", clk_out[2], tick[2]);
      end
      for (int k = 0; k < 2; k++) step();
      en[2] = 1'b1;
      first = -1;
      for (int k = 1; k <= 20; k++) begin
         step();
         vectors++;
         if ({clk_out, tick, div_pend} !== {exp_clk, exp_tick, exp_pend}) begin
            miscompares++;
            $display("FAIL reenable_model cyc=%0d got %b/%b/%b exp %b/%b/%b", cyc, clk_out, tick, div_pend, exp_clk, exp_tick, exp_pend);
         end
         if (first < 0 && tick[2]) first = k;
      end
      vectors++;
      if (first != 9) begin
         miscompares++;
         $display("FAIL reenable_first got %0d exp 9", first);
      end
      for (int k = 0; k < 3; k++) step();
      #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({clk_out, tick, div_pend} !== '0) begin
         miscompares++;
         $display("FAIL async_reset got clk=%b tick=%b pend=%b exp all zero", clk_out, tick, div_pend);
      end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         step();
         vectors++;
         if ({clk_out, tick, div_pend} !== {exp_clk, exp_tick, exp_pend} || tick[1] !== (k == 10)) begin
            miscompares++;
            $display("FAIL post_reset edge=%0d got %b/%b/%b exp %b/%b/%b", k, clk_out, tick, div_pend, exp_clk, exp_tick, exp_pend);
         end
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         for (int i = 0; i < NUM_CH; i++) begin
            en[i]     = ($urandom_range(0, 7) != 0);
            div_wr[i] = ($urandom_range(0, 9) == 0);
            div_in[i*CNT_W +: CNT_W] = 16'($urandom_range(0, 12));
         end
         sync = ($urandom_range(0, 39) == 0);
         step();
         vectors++;
         if ({clk_out, tick, div_pend} !== {exp_clk, exp_tick, exp_pend}) begin
            miscompares++;
            $display("FAIL random_model cyc=%0d got %b/%b/%b exp %b/%b/%b", cyc, clk_out, tick, div_pend, exp_clk, exp_tick, exp_pend);
         end
      end
      en = '1; sync = 1'b0; div_wr = '0;
   endtask

   initial begin
      test_reset();
      test_default_div();
      test_write_three();
      test_clamp();
      test_last_write();
      test_sync();
      test_disable_and_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
